// File: rtl/pe_ws_db_pkg.sv
// Shared defaults for the weight-stationary PE and its helpers.
package pe_ws_db_pkg;

  // Default activation/weight width (weights are always signed).
  localparam int DEF_DATA_WIDTH = 8;
  // Default partial-sum width (signed).
  localparam int DEF_ACC_WIDTH  = 32;
  // Default overflow behaviour: 1 = clamp, 0 = two's-complement wrap.
  localparam int DEF_SATURATE   = 1;

endpackage

// File: rtl/pe_sat_add.sv
// Reduces an (ACC_WIDTH+1)-bit sum to ACC_WIDTH bits, either clamping or
// wrapping, and reports whether the sum left the ACC_WIDTH range.
module pe_sat_add #(
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH:0]   sum_i,
  output logic [ACC_WIDTH-1:0] res_o,
  output logic                 ovf_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Out of range when the guard bit disagrees with the result sign bit;
  // the guard bit then gives the true sign and picks the clamp rail.
  always_comb begin
    ovf_o = sum_i[ACC_WIDTH] ^ sum_i[ACC_WIDTH-1];
    res_o = sum_i[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && ovf_o) begin
      res_o = sum_i[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary processing element with a double-buffered weight
// (shadow loaded through the column chain, active used by the MAC),
// valid-qualified streams, optional saturation and sticky flags.
// Every output is a register; en=0 freezes all state.
module pe_ws_db
  import pe_ws_db_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  // ACC_WIDTH >= 2*DATA_WIDTH keeps the product exact inside the sum.
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  act_signed,
  input  logic [DATA_WIDTH-1:0] in_act,
  input  logic                  in_act_valid,
  output logic [DATA_WIDTH-1:0] out_act,
  output logic                  out_act_valid,
  input  logic [ACC_WIDTH-1:0]  in_psum,
  input  logic                  in_psum_valid,
  output logic [ACC_WIDTH-1:0]  out_psum,
  output logic                  out_psum_valid,
  input  logic                  w_shift,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic                  in_w_valid,
  output logic [DATA_WIDTH-1:0] out_w,
  output logic                  out_w_valid,
  input  logic                  w_swap,
  input  logic                  clr_flags,
  output logic                  ovf_flag,
  output logic                  nowt_flag
);

  localparam int PW = 2 * DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] shadow_w_q, shadow_w_d, active_w_q, active_w_d;
  logic                  shadow_vld_q, shadow_vld_d, active_vld_q, active_vld_d;
  logic [DATA_WIDTH-1:0] act_q, act_d;
  logic                  act_vld_q, act_vld_d;
  logic [ACC_WIDTH-1:0]  psum_q, psum_d;
  logic                  psum_vld_q, psum_vld_d;
  logic                  ovf_q, ovf_d, nowt_q, nowt_d;

  logic                  mac_en;
  logic [DATA_WIDTH:0]   act_ext;
  logic signed [PW-1:0]  act_x, w_x, prod;
  logic signed [ACC_WIDTH:0] prod_x, sum;
  logic [ACC_WIDTH-1:0]  sat_res;
  logic                  sat_ovf;

  // Operand extension and gated product; the product is forced to zero
  // when the activation is invalid or no weight is loaded.
  always_comb begin
    mac_en  = in_act_valid & active_vld_q;
    act_ext = {act_signed & in_act[DATA_WIDTH-1], in_act};
    act_x   = {{DATA_WIDTH{act_ext[DATA_WIDTH]}}, act_ext};
    w_x     = {{(DATA_WIDTH+1){active_w_q[DATA_WIDTH-1]}}, active_w_q};
    prod    = mac_en ? act_x * w_x : '0;
    prod_x  = (ACC_WIDTH+1)'(prod);
    sum     = $signed({in_psum[ACC_WIDTH-1], in_psum}) + prod_x;
  end

  pe_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat_add (
    .sum_i (sum),
    .res_o (sat_res),
    .ovf_o (sat_ovf)
  );

  // Next-state: hold by default; with en, shift/swap/pass/MAC/flags update.
  // Swap reads the pre-shift shadow, so shift+swap in one cycle is legal.
  always_comb begin
    shadow_w_d   = shadow_w_q;
    shadow_vld_d = shadow_vld_q;
    active_w_d   = active_w_q;
    active_vld_d = active_vld_q;
    act_d        = act_q;
    act_vld_d    = act_vld_q;
    psum_d       = psum_q;
    psum_vld_d   = psum_vld_q;
    ovf_d        = ovf_q;
    nowt_d       = nowt_q;
    if (en) begin
      if (w_shift) begin
        shadow_w_d   = in_w;
        shadow_vld_d = in_w_valid;
      end
      if (w_swap) begin
        active_w_d   = shadow_w_q;
        active_vld_d = shadow_vld_q;
      end
      act_d      = in_act;
      act_vld_d  = in_act_valid;
      psum_d     = sat_res;
      psum_vld_d = in_psum_valid;
      if (sat_ovf)        ovf_d = 1'b1;
      else if (clr_flags) ovf_d = 1'b0;
      if (in_act_valid && !active_vld_q) nowt_d = 1'b1;
      else if (clr_flags)                nowt_d = 1'b0;
    end
  end

  // State register; asynchronous reset clears everything, outputs included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w_q   <= '0;
      shadow_vld_q <= 1'b0;
      active_w_q   <= '0;
      active_vld_q <= 1'b0;
      act_q        <= '0;
      act_vld_q    <= 1'b0;
      psum_q       <= '0;
      psum_vld_q   <= 1'b0;
      ovf_q        <= 1'b0;
      nowt_q       <= 1'b0;
    end else begin
      shadow_w_q   <= shadow_w_d;
      shadow_vld_q <= shadow_vld_d;
      active_w_q   <= active_w_d;
      active_vld_q <= active_vld_d;
      act_q        <= act_d;
      act_vld_q    <= act_vld_d;
      psum_q       <= psum_d;
      psum_vld_q   <= psum_vld_d;
      ovf_q        <= ovf_d;
      nowt_q       <= nowt_d;
    end
  end

  assign out_act        = act_q;
  assign out_act_valid  = act_vld_q;
  assign out_psum       = psum_q;
  assign out_psum_valid = psum_vld_q;
  assign out_w          = shadow_w_q;
  assign out_w_valid    = shadow_vld_q;
  assign ovf_flag       = ovf_q;
  assign nowt_flag      = nowt_q;

endmodule

// File: tb/tb_pe_ws_db.sv
// Bench for pe_ws_db: two 16-bit-accumulator instances (saturating and
// wrapping) share all inputs. Stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares whenever out_psum_valid updates.
module tb_pe_ws_db;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, act_signed, in_act_valid, in_psum_valid;
  logic        w_shift, in_w_valid, w_swap, clr_flags;
  logic [7:0]  in_act, in_w;
  logic [15:0] in_psum;

  logic [7:0]  oa_s, oa_w, ow_s, ow_w;
  logic [15:0] op_s, op_w;
  logic        oav_s, oav_w, opv_s, opv_w, owv_s, owv_w;
  logic        ovf_s, ovf_w, nowt_s, nowt_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [39:0] exp_q[$];  // {out_act, psum_saturating, psum_wrapping}
  logic        en_at_edge;

  always #5 clk = ~clk;

  pe_ws_db #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .act_signed(act_signed),
    .in_act(in_act), .in_act_valid(in_act_valid),
    .out_act(oa_s), .out_act_valid(oav_s),
    .in_psum(in_psum), .in_psum_valid(in_psum_valid),
    .out_psum(op_s), .out_psum_valid(opv_s),
    .w_shift(w_shift), .in_w(in_w), .in_w_valid(in_w_valid),
    .out_w(ow_s), .out_w_valid(owv_s), .w_swap(w_swap),
    .clr_flags(clr_flags), .ovf_flag(ovf_s), .nowt_flag(nowt_s)
  );

  pe_ws_db #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .act_signed(act_signed),
    .in_act(in_act), .in_act_valid(in_act_valid),
    .out_act(oa_w), .out_act_valid(oav_w),
    .in_psum(in_psum), .in_psum_valid(in_psum_valid),
    .out_psum(op_w), .out_psum_valid(opv_w),
    .w_shift(w_shift), .in_w(in_w), .in_w_valid(in_w_valid),
    .out_w(ow_w), .out_w_valid(owv_w), .w_swap(w_swap),
    .clr_flags(clr_flags), .ovf_flag(ovf_w), .nowt_flag(nowt_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remember whether the last rising edge actually updated the registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_at_edge <= 1'b0;
    else        en_at_edge <= en;
  end

  // Monitor: one expected entry per enabled edge that produced a valid psum.
  always @(negedge clk) begin
    if (rst_n && en_at_edge && opv_s) begin
      check("psum_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("out_act", 32'(oa_s), 32'(e[39:32]));
        check("psum_sat", 32'(op_s), 32'(e[31:16]));
        check("psum_wrap", 32'(op_w), 32'(e[15:0]));
        check("psum_vld_wrap", 32'(opv_w), 32'd1);
      end
    end
  end

  // Driver: apply one cycle of stream inputs, record expectation, then
  // drop the one-shot control strobes.
  task automatic cyc(input logic [7:0] a, input logic av, input logic [15:0] p,
                     input logic pv, input logic [15:0] es, input logic [15:0] ew);
    in_act = a; in_act_valid = av; in_psum = p; in_psum_valid = pv;
    if (pv && en) exp_q.push_back({a, es, ew});
    @(posedge clk); #1;
    w_shift = 1'b0; w_swap = 1'b0; clr_flags = 1'b0; in_w_valid = 1'b0;
  endtask

  task automatic shift_w(input logic [7:0] w);
    w_shift = 1'b1; in_w = w; in_w_valid = 1'b1;
    cyc(8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic swap();
    w_swap = 1'b1;
    cyc(8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_act"}, 32'({oa_s, oav_s, oa_w, oav_w}), 32'd0);
    check({tag, "_psum"}, 32'({op_s, opv_s, op_w, opv_w}), 32'd0);
    check({tag, "_w"}, 32'({ow_s, owv_s, ow_w, owv_w}), 32'd0);
    check({tag, "_flags"}, 32'({ovf_s, nowt_s, ovf_w, nowt_w}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; act_signed = 1'b1;
    in_act = '0; in_act_valid = 1'b0; in_psum = '0; in_psum_valid = 1'b0;
    w_shift = 1'b0; in_w = '0; in_w_valid = 1'b0; w_swap = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Load/swap: -3 * 5 + 100 = 85
    shift_w(8'hFD);
    swap();
    cyc(8'd5, 1'b1, 16'd100, 1'b1, 16'd85, 16'd85);
    check("load_out_w", 32'({ow_s, owv_s}), 32'({8'hFD, 1'b1}));
    check("load_nowt", 32'(nowt_s), 32'd0);

    // Double buffer: active=2, shift 7 in, swap while act=3 is sampled
    shift_w(8'd2);
    swap();
    w_shift = 1'b1; in_w = 8'd7; in_w_valid = 1'b1;
    cyc(8'd1, 1'b1, 16'd0, 1'b1, 16'd2, 16'd2);
    cyc(8'd2, 1'b1, 16'd0, 1'b1, 16'd4, 16'd4);
    w_swap = 1'b1;
    cyc(8'd3, 1'b1, 16'd0, 1'b1, 16'd6, 16'd6);
    cyc(8'd4, 1'b1, 16'd0, 1'b1, 16'd28, 16'd28);
    check("dbuf_out_w", 32'(ow_s), 32'd7);

    // Unsigned vs signed activation with w=-1
    shift_w(8'hFF);
    swap();
    act_signed = 1'b0;
    cyc(8'hFF, 1'b1, 16'd0, 1'b1, 16'hFF01, 16'hFF01);
    act_signed = 1'b1;
    cyc(8'hFF, 1'b1, 16'd0, 1'b1, 16'h0001, 16'h0001);

    // Saturation / wrap, both rails, flag clear and set-wins
    shift_w(8'd1);
    swap();
    cyc(8'd1, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 16'h8000);
    check("ovf_pos", 32'({ovf_s, ovf_w}), 32'b11);
    clr_flags = 1'b1;
    cyc(8'd0, 1'b0, 16'd0, 1'b1, 16'd0, 16'd0);
    check("ovf_clr", 32'({ovf_s, ovf_w}), 32'b00);
    cyc(8'h80, 1'b1, 16'h8000, 1'b1, 16'h8000, 16'h7F80);
    check("ovf_neg", 32'({ovf_s, ovf_w}), 32'b11);
    clr_flags = 1'b1;
    cyc(8'd1, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, 16'h8000);
    check("ovf_set_wins", 32'({ovf_s, ovf_w}), 32'b11);
    clr_flags = 1'b1;
    cyc(8'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0);
    check("ovf_clr2", 32'({ovf_s, ovf_w}), 32'b00);

    // Invalid activation passes psum through, nowt untouched
    cyc(8'd9, 1'b0, 16'd40, 1'b1, 16'd40, 16'd40);
    check("inval_nowt", 32'({nowt_s, nowt_w}), 32'b00);

    // Stall: everything frozen for 3 cycles, then resume
    cyc(8'd2, 1'b1, 16'd10, 1'b1, 16'd12, 16'd12);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_shift = 1'b1; in_w = 8'h55; in_w_valid = 1'b1; w_swap = 1'b1;
      clr_flags = 1'b1;
      cyc(8'(20 + i), 1'b1, 16'd999, 1'b0, 16'd0, 16'd0);
      check("stall_psum", 32'({op_s, opv_s}), 32'({16'd12, 1'b1}));
      check("stall_act", 32'({oa_s, oav_s}), 32'({8'd2, 1'b1}));
      check("stall_w", 32'({ow_s, owv_s}), 32'({8'd1, 1'b1}));
    end
    en = 1'b1;
    cyc(8'd3, 1'b1, 16'd10, 1'b1, 16'd13, 16'd13);
    cyc(8'd5, 1'b1, 16'd10, 1'b0, 16'd0, 16'd0);
    check("pre_reset_act", 32'({oa_s, oav_s}), 32'({8'd5, 1'b1}));

    // Asynchronous reset between edges clears outputs immediately
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // No weight loaded: pass-through psum and nowt set
    cyc(8'd4, 1'b1, 16'd10, 1'b1, 16'd10, 16'd10);
    check("nowt_set", 32'({nowt_s, nowt_w}), 32'b11);
    check("nowt_ovf", 32'({ovf_s, ovf_w}), 32'b00);

    cyc(8'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0);
    cyc(8'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
